// File: rtl/yt_irq_pkg.sv
// Shared constants for the interrupt request controller: config register map
// and STATUS field layout.
package yt_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_ADDR_MASK = 2'd0,
    IRQ_ADDR_EDGE = 2'd1,
    IRQ_ADDR_PEND = 2'd2,
    IRQ_ADDR_STAT = 2'd3
  } irq_addr_e;

  localparam int IRQ_ID_W       = 3;
  localparam int STAT_ID_LSB    = 0;
  localparam int STAT_VALID_BIT = 4;

endpackage

// File: rtl/irq_sync.sv
// Single-bit synchroniser: SYNC_STAGES flops bringing an asynchronous line
// into the clk domain. Synchronous active-low reset.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Interrupt request controller: synchronises device lines, latches them as
// pending (edge or level per line), masks them and drives a registered request.
module irq_controller
  import yt_irq_pkg::*;
#(
  parameter int               N_IRQ       = 5,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_RST    = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    i_irq_src,
  input  logic                i_cfg_we,
  input  logic [1:0]          i_cfg_addr,
  input  logic [31:0]         i_cfg_wdata,
  output logic [31:0]         o_cfg_rdata,
  input  logic                i_ack,
  input  logic [IRQ_ID_W-1:0] i_ack_id,
  output logic [N_IRQ-1:0]    o_interruption,
  output logic                o_irq_valid,
  output logic [IRQ_ID_W-1:0] o_irq_id
);

  // Handshake: i_cfg_we and i_ack are single-cycle strobes sampled at posedge;
  // there is no ready, every strobe outside reset is accepted in its own cycle.

  logic [N_IRQ-1:0]    s;
  logic [N_IRQ-1:0]    prev;
  logic [N_IRQ-1:0]    pending;
  logic [N_IRQ-1:0]    pending_nxt;
  logic [N_IRQ-1:0]    mask;
  logic [N_IRQ-1:0]    edge_sel;
  logic [N_IRQ-1:0]    rise;
  logic [N_IRQ-1:0]    clr;
  logic [N_IRQ-1:0]    active;
  logic [N_IRQ-1:0]    wdata_lo;
  logic [IRQ_ID_W-1:0] irq_id_nxt;
  logic                wr_mask;
  logic                wr_edge;
  logic                wr_pend;
  logic                unused_wdata_hi;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_irq_src[g]),
      .q     (s[g])
    );
  end

  assign wdata_lo        = i_cfg_wdata[N_IRQ-1:0];
  assign unused_wdata_hi = ^i_cfg_wdata[31:N_IRQ];
  assign wr_mask         = i_cfg_we && (i_cfg_addr == IRQ_ADDR_MASK);
  assign wr_edge         = i_cfg_we && (i_cfg_addr == IRQ_ADDR_EDGE);
  assign wr_pend         = i_cfg_we && (i_cfg_addr == IRQ_ADDR_PEND);
  assign active          = pending & mask;

  // Edge lines: a new rise beats a same-cycle clear. Level lines just follow s.
  always_comb begin
    rise        = s & ~prev;
    clr         = '0;
    pending_nxt = '0;
    if (wr_pend) clr = wdata_lo;
    for (int i = 0; i < N_IRQ; i++) begin
      if (i_ack && (i_ack_id == IRQ_ID_W'(i))) clr[i] = 1'b1;
      pending_nxt[i] = edge_sel[i] ? (rise[i] | (pending[i] & ~clr[i])) : s[i];
    end
  end

  always_comb begin
    irq_id_nxt = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id_nxt = IRQ_ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev           <= '0;
      pending        <= '0;
      mask           <= '0;
      edge_sel       <= EDGE_RST;
      o_interruption <= '0;
      o_irq_valid    <= 1'b0;
      o_irq_id       <= '0;
    end else begin
      prev           <= s;
      pending        <= pending_nxt;
      if (wr_mask) mask <= wdata_lo;
      if (wr_edge) edge_sel <= wdata_lo;
      o_interruption <= active;
      o_irq_valid    <= |active;
      o_irq_id       <= irq_id_nxt;
    end
  end

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      IRQ_ADDR_MASK: o_cfg_rdata[N_IRQ-1:0] = mask;
      IRQ_ADDR_EDGE: o_cfg_rdata[N_IRQ-1:0] = edge_sel;
      IRQ_ADDR_PEND: o_cfg_rdata[N_IRQ-1:0] = pending;
      IRQ_ADDR_STAT: begin
        o_cfg_rdata[STAT_VALID_BIT]             = o_irq_valid;
        o_cfg_rdata[STAT_ID_LSB +: IRQ_ID_W]    = o_irq_id;
      end
      default: o_cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_irq_controller;

  localparam int N    = 5;
  localparam int SYNC = 2;

  logic          clk;
  logic          reset;
  logic [N-1:0]  i_irq_src;
  logic          i_cfg_we;
  logic [1:0]    i_cfg_addr;
  logic [31:0]   i_cfg_wdata;
  logic [31:0]   o_cfg_rdata;
  logic          i_ack;
  logic [2:0]    i_ack_id;
  logic [N-1:0]  o_interruption;
  logic          o_irq_valid;
  logic [2:0]    o_irq_id;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .i_irq_src      (i_irq_src),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_addr     (i_cfg_addr),
    .i_cfg_wdata    (i_cfg_wdata),
    .o_cfg_rdata    (o_cfg_rdata),
    .i_ack          (i_ack),
    .i_ack_id       (i_ack_id),
    .o_interruption (o_interruption),
    .o_irq_valid    (o_irq_valid),
    .o_irq_id       (o_irq_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] is the raw source sampled k+1 edges ago; the controller sees a
  // source SYNC edges late, so a line's rise is judged from hist[SYNC-1] vs hist[SYNC].
  logic [N-1:0] hist [0:SYNC];
  logic [N-1:0] m_pend, m_mask, m_edge, m_int;
  logic         m_valid;
  logic [2:0]   m_id;
  bit           model_ready = 0;

  function automatic logic [2:0] lowest(input logic [N-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0: r = 32'(m_mask);
      2'd1: r = 32'(m_edge);
      2'd2: r = 32'(m_pend);
      default: r = (32'(m_valid) << 4) | 32'(m_id);
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] now_s, old_s, act, clr, nxt;
    if (!reset) begin
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      m_pend = '0; m_mask = '0; m_edge = '1;
      m_int = '0; m_valid = 1'b0; m_id = 3'd0;
    end else begin
      act     = m_pend & m_mask;
      m_int   = act;
      m_valid = (act != 0);
      m_id    = lowest(act);
      now_s   = hist[SYNC-1];
      old_s   = hist[SYNC];
      clr     = '0;
      if (i_cfg_we && i_cfg_addr == 2'd2) clr = i_cfg_wdata[N-1:0];
      if (i_ack && int'(i_ack_id) < N) clr[i_ack_id] = 1'b1;
      for (int i = 0; i < N; i++)
        nxt[i] = m_edge[i] ? ((now_s[i] && !old_s[i]) || (m_pend[i] && !clr[i])) : now_s[i];
      m_pend = nxt;
      if (i_cfg_we && i_cfg_addr == 2'd0) m_mask = i_cfg_wdata[N-1:0];
      if (i_cfg_we && i_cfg_addr == 2'd1) m_edge = i_cfg_wdata[N-1:0];
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = i_irq_src;
    end
    model_ready = 1;
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_ready) begin
      check("cyc_interruption", 32'(o_interruption), 32'(m_int));
      check("cyc_valid", 32'(o_irq_valid), 32'(m_valid));
      check("cyc_id", 32'(o_irq_id), 32'(m_id));
      check("cyc_rdata", o_cfg_rdata, model_rdata(i_cfg_addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_wdata = d;
    tick(1);
    i_cfg_we = 1'b0;
  endtask

  task automatic ack(input logic [2:0] id);
    i_ack = 1'b1; i_ack_id = id;
    tick(1);
    i_ack = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    i_cfg_addr = a;
    #1;
    check(name, o_cfg_rdata, exp);
  endtask

  task automatic outs(input logic [N-1:0] e_int, input logic e_valid, input logic [2:0] e_id,
                      input string name);
    check({name, "_int"}, 32'(o_interruption), 32'(e_int));
    check({name, "_valid"}, 32'(o_irq_valid), 32'(e_valid));
    check({name, "_id"}, 32'(o_irq_id), 32'(e_id));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b0; i_irq_src = 5'h1F; i_cfg_we = 1'b0; i_cfg_addr = 2'd2;
    i_cfg_wdata = 32'd0; i_ack = 1'b0; i_ack_id = 3'd0;

    // 1: reset holds everything at zero, masked lines still latch afterwards
    tick(4);
    outs(5'h00, 1'b0, 3'd0, "rst_hold");
    rd(2'd2, 32'h0, "rst_pending");
    reset = 1'b1;
    tick(6);
    outs(5'h00, 1'b0, 3'd0, "rst_release_masked");
    rd(2'd2, 32'h1F, "rst_masked_latch");
    i_irq_src = 5'h00;
    tick(4);
    wr(2'd2, 32'h1F);
    rd(2'd2, 32'h0, "w1c_all");

    // 2: edge path latency and ack
    wr(2'd0, 32'h1F);
    i_irq_src = 5'h04;
    tick(3);
    outs(5'h00, 1'b0, 3'd0, "edge_before_lat");
    tick(1);
    outs(5'h04, 1'b1, 3'd2, "edge_lat3");
    rd(2'd3, 32'h12, "status_id2");
    ack(3'd2);
    outs(5'h04, 1'b1, 3'd2, "ack_edge_k");
    tick(1);
    outs(5'h00, 1'b0, 3'd0, "ack_drop");
    tick(5);
    outs(5'h00, 1'b0, 3'd0, "no_retrigger");

    // 3: priority and mask
    i_irq_src = 5'h0E;
    tick(2);
    i_irq_src = 5'h04;
    tick(5);
    outs(5'h0A, 1'b1, 3'd1, "prio_low");
    wr(2'd0, 32'h1D);
    tick(1);
    outs(5'h08, 1'b1, 3'd3, "prio_masked");
    wr(2'd2, 32'h1F);
    wr(2'd0, 32'h1F);
    tick(2);
    outs(5'h00, 1'b0, 3'd0, "prio_cleared");

    // 4: set/clear collision and out-of-range ack
    i_irq_src = 5'h05;
    tick(2);
    i_irq_src = 5'h04;
    tick(6);
    outs(5'h01, 1'b1, 3'd0, "coll_setup");
    i_irq_src = 5'h05;
    tick(2);
    ack(3'd0);
    rd(2'd2, 32'h01, "coll_set_wins");
    ack(3'd7);
    rd(2'd2, 32'h01, "ack7_ignored");
    ack(3'd0);
    rd(2'd2, 32'h00, "ack0_clears");
    tick(2);
    outs(5'h00, 1'b0, 3'd0, "coll_done");

    // 5: level mode
    i_irq_src = 5'h00;
    tick(4);
    wr(2'd1, 32'h0);
    i_irq_src = 5'h10;
    tick(5);
    outs(5'h10, 1'b1, 3'd4, "level_high");
    wr(2'd2, 32'h10);
    tick(2);
    outs(5'h10, 1'b1, 3'd4, "level_w1c_noeffect");
    rd(2'd2, 32'h10, "level_pending");
    i_irq_src = 5'h00;
    tick(4);
    outs(5'h00, 1'b0, 3'd0, "level_low");
    wr(2'd1, 32'h1F);

    // 6: reset mid-operation, config write during reset ignored
    i_irq_src = 5'h0A;
    tick(2);
    i_irq_src = 5'h00;
    tick(6);
    outs(5'h0A, 1'b1, 3'd1, "mid_pending");
    rd(2'd2, 32'h0A, "mid_pending_rd");
    reset = 1'b0;
    i_cfg_we = 1'b1; i_cfg_addr = 2'd1; i_cfg_wdata = 32'h0;
    tick(1);
    reset = 1'b1; i_cfg_we = 1'b0;
    outs(5'h00, 1'b0, 3'd0, "mid_reset");
    rd(2'd0, 32'h0, "mid_mask");
    rd(2'd1, 32'h1F, "mid_edge_sel");
    tick(1);
    rd(2'd2, 32'h0, "mid_pend");
    tick(4);
    outs(5'h00, 1'b0, 3'd0, "mid_quiet");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
